vu_bus_initiator: RTL and testbench
===================================

Name: vu_bus_initiator

Overview:
- Synthesizable initiator for the Vector-06c expansion (ВУ) bus: executes one memory or I/O bus cycle per request.
- Generates the status word with STROB_SOST, multiplexed RAS/CAS address on ШАП, port address on ШАВВ, and the ЗПЗУ/ЧТЗУ/ЗПВВ/ЧТВВ strobes.
- Captures read data and the responder's ~БЛК.
- Drives the board's bus-side responder logic in loopback self-test and in bench harnesses, standing in for the host CPU side of the interface.

Parameters:
T_STROB, 4, cycles STROB_SOST is held high
T_ROW, 3, cycles of row address (mem) or port-address setup (I/O) before the next phase
T_COL, 3, cycles of column address with CAS low before the strobe (mem only)
T_ACC, 8, cycles the read/write strobe is held low
T_REL, 2, cycles of recovery after the strobe, with address and write data still held

Ports:
clk_cpu  in  1  clock
sys_reset  in  1  asynchronous, active-high reset
req  in  1  start pulse; sampled only in IDLE
req_kind  in  3  0=MEMRD, 1=MEMWR, 2=IORD, 3=IOWR, 4=M1 fetch; 5..7 are illegal
req_stack  in  1  sets status bit2 (STACK) and drives vu_stack during the cycle
req_addr  in  16  memory address; for I/O only [7:0] is used
req_wdata  in  8  write data
busy  out  1  cycle in progress
ack  out  1  one-cycle completion pulse
rdata  out  8  captured read data, held until the next read
blk_seen  out  1  ~БЛК was sampled low during the strobe of the last cycle
vu_shap_n  out  8  multiplexed address, inverted
vu_shavv_n  out  8  port address, inverted
vu_shd_o  out  8  data/status out
vu_shd_oe  out  1  data driver enable
vu_shd_i  in  8  data in
vu_ras_n, vu_cas_n, vu_zpzu_n, vu_chtzu_n, vu_zpvv_n, vu_chtvv_n  out  1 each  active-low strobes
vu_stack  out  1  stack flag
vu_strob_sost  out  1  status strobe
vu_blk_n  in  1  responder block, active low

Behaviour:
- Reset (async, immediate, also mid-cycle):
  - All _n outputs 1; vu_shap_n and vu_shavv_n = 8'hFF.
  - vu_shd_oe=0, vu_shd_o=0, vu_strob_sost=0, vu_stack=0.
  - busy=0, ack=0, rdata=8'h00, blk_seen=0.
  - FSM goes to IDLE; no partial strobe may survive reset.
- FSM states: IDLE, STAT, STAT_HOLD, ROW, COL, ACC, REL, DONE. One down-counter is loaded on each phase entry.
- IDLE:
  - If req=1 and req_kind ≤ 4: latch kind, stack, addr and wdata; go to STAT; busy=1 from the next cycle.
  - If req_kind ≥ 5: ignore the request (no ack).
  - A req while busy is ignored; there is no queue.
- Status word PSW:
  - MEMRD 0x82, M1 0xA2, MEMWR 0x00, IORD 0x42, IOWR 0x10.
  - OR 0x04 into PSW when stack=1.
- STAT: T_STROB cycles; vu_shd_oe=1, vu_shd_o=PSW, vu_strob_sost=1.
- STAT_HOLD: 1 cycle; PSW still driven, vu_strob_sost=0. Responders latch PSW on the STROB_SOST falling/rising edge plus a sync margin.
- Memory cycles:
  - ROW (T_ROW cycles): vu_shap_n=~addr[7:0], vu_ras_n=0.
  - COL (T_COL cycles): vu_shap_n=~addr[15:8], vu_cas_n=0; RAS stays low.
  - ACC (T_ACC cycles): vu_chtzu_n=0 (MEMRD/M1) or vu_zpzu_n=0 (MEMWR).
  - REL (T_REL cycles): strobe high; RAS/CAS and address held; vu_ras_n/vu_cas_n rise on REL exit.
- I/O cycles:
  - ROW (T_ROW cycles): vu_shavv_n=~addr[7:0]. No RAS/CAS activity; COL is skipped.
  - ACC (T_ACC cycles): vu_chtvv_n=0 (IORD) or vu_zpvv_n=0 (IOWR).
  - REL (T_REL cycles): vu_shavv_n held.
- Write data: for writes, vu_shd_oe=1 with vu_shd_o=wdata from ROW entry through the end of REL. For reads, vu_shd_oe=0 from ROW onward.
- Read capture: rdata <= vu_shd_i on the last ACC cycle. rdata is unchanged by write cycles.
- blk_seen:
  - Cleared at STAT entry.
  - Set if vu_blk_n=0 on any ACC cycle.
- DONE:
  - 1 cycle: ack=1, busy=0; all bus outputs are idle values.
  - Next state is IDLE; a req during DONE is ignored.
- Latency, counted from the accepting edge to ack:
  - Memory: T_STROB+1+T_ROW+T_COL+T_ACC+T_REL+1, which is 22 with defaults.
  - I/O: T_STROB+1+T_ROW+T_ACC+T_REL+1, which is 19 with defaults.
- Strobe exclusivity: at most one of the four strobes is low at any time. RAS/CAS are never low during an I/O cycle.

Test Plan:
- MEMRD addr 0x1234, responder returns 0x5A with blk_n low during ACC -> PSW 0x82 on shd during STAT; shap_n=0xCB with ras_n=0, then 0xED with cas_n=0; chtzu_n low 8 cycles; ack 22 cycles after accept; rdata=0x5A, blk_seen=1.
- MEMWR addr 0xFFFF, wdata 0xA5, stack=1 -> PSW 0x04; shd=0xA5 from ROW through REL; zpzu_n low 8 cycles; vu_stack=1; blk_seen=0 with blk_n high; rdata unchanged.
- IOWR port 0x10, data 0x23 -> PSW 0x10; shavv_n=0xEF; ras_n/cas_n stay 1; zpvv_n low 8 cycles; ack at 19 cycles.
- IORD port 0x1B, shd_i=0x80 -> PSW 0x42; chtvv_n low; rdata=0x80; ack at 19 cycles.
- Second req while busy, and a req with req_kind=6 -> ignored: exactly one ack and no bus activity for the ignored requests.
- sys_reset asserted mid-ACC of a MEMWR -> zpzu_n, ras_n and cas_n go to 1 and shd_oe to 0 combinationally-async; busy=0; the next req runs a full normal cycle.

Source files
------------

// File: rtl/vu_bus_initiator.sv
// ---------------------------------------------------------------------------
// vu_bus_initiator
//
// Bus-cycle initiator for the Vector-06c expansion (VU) bus. Each accepted
// request runs exactly one memory or I/O cycle: a status word (PSW) phase with
// STROB_SOST, then either a RAS/CAS multiplexed memory access on SHAP or a
// port access on SHAVV, a read/write strobe, and a recovery phase. Read data
// and the responder's block line are captured for the requester.
//
// Ports:
//   clk_cpu, sys_reset          clock, asynchronous active-high reset
//   req, req_kind, req_stack    request pulse, cycle kind (0..4), stack flag
//   req_addr, req_wdata         address (I/O uses [7:0]) and write data
//   busy, ack                   cycle in progress, one-cycle completion pulse
//   rdata, blk_seen             captured read data, block seen during strobe
//   vu_shap_n, vu_shavv_n       inverted memory / port address buses
//   vu_shd_o, vu_shd_oe, vu_shd_i  data bus out / enable / in
//   vu_ras_n .. vu_chtvv_n      active-low bus strobes
//   vu_stack, vu_strob_sost     stack flag and status strobe
//   vu_blk_n                    responder block input, active low
//
// All bus outputs are decoded combinationally from the state register, which
// resets asynchronously, so a reset removes every strobe immediately.
// ---------------------------------------------------------------------------
module vu_bus_initiator #(
    parameter int unsigned T_STROB = 4,
    parameter int unsigned T_ROW   = 3,
    parameter int unsigned T_COL   = 3,
    parameter int unsigned T_ACC   = 8,
    parameter int unsigned T_REL   = 2
) (
    input  logic        clk_cpu,
    input  logic        sys_reset,
    input  logic        req,
    input  logic [2:0]  req_kind,
    input  logic        req_stack,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        busy,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        blk_seen,
    output logic [7:0]  vu_shap_n,
    output logic [7:0]  vu_shavv_n,
    output logic [7:0]  vu_shd_o,
    output logic        vu_shd_oe,
    input  logic [7:0]  vu_shd_i,
    output logic        vu_ras_n,
    output logic        vu_cas_n,
    output logic        vu_zpzu_n,
    output logic        vu_chtzu_n,
    output logic        vu_zpvv_n,
    output logic        vu_chtvv_n,
    output logic        vu_stack,
    output logic        vu_strob_sost,
    input  logic        vu_blk_n
);

    localparam logic [2:0] K_MEMRD = 3'd0;
    localparam logic [2:0] K_MEMWR = 3'd1;
    localparam logic [2:0] K_IORD  = 3'd2;
    localparam logic [2:0] K_IOWR  = 3'd3;
    localparam logic [2:0] K_M1    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_STAT, S_STAT_HOLD, S_ROW, S_COL, S_ACC, S_REL, S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;

    // Request fields latched at acceptance
    logic [2:0]  kind_l;
    logic        stack_l;
    logic [15:0] addr_l;
    logic [7:0]  wdata_l;

    logic accept;
    logic is_mem;
    logic is_wr;

    assign accept = req && (req_kind <= K_M1);
    assign is_mem = (kind_l == K_MEMRD) || (kind_l == K_MEMWR) || (kind_l == K_M1);
    assign is_wr  = (kind_l == K_MEMWR) || (kind_l == K_IOWR);

    // Counter load value for a phase: the phase lasts load+1 cycles.
    function automatic logic [7:0] phase_len(input state_t s);
        case (s)
            S_STAT:  phase_len = 8'(T_STROB - 1);
            S_ROW:   phase_len = 8'(T_ROW - 1);
            S_COL:   phase_len = 8'(T_COL - 1);
            S_ACC:   phase_len = 8'(T_ACC - 1);
            S_REL:   phase_len = 8'(T_REL - 1);
            default: phase_len = 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] psw_of(input logic [2:0] k, input logic stk);
        logic [7:0] p;
        case (k)
            K_MEMRD: p = 8'h82;
            K_M1:    p = 8'hA2;
            K_MEMWR: p = 8'h00;
            K_IORD:  p = 8'h42;
            K_IOWR:  p = 8'h10;
            default: p = 8'h00;
        endcase
        psw_of = p | (stk ? 8'h04 : 8'h00);
    endfunction

    // State register and phase counter
    always_ff @(posedge clk_cpu or posedge sys_reset) begin
        if (sys_reset) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic; the counter reloads whenever the phase changes.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (accept)     state_nx = S_STAT;
            S_STAT:      if (cnt == 8'd0) state_nx = S_STAT_HOLD;
            S_STAT_HOLD:                 state_nx = S_ROW;
            S_ROW:       if (cnt == 8'd0) state_nx = is_mem ? S_COL : S_ACC;
            S_COL:       if (cnt == 8'd0) state_nx = S_ACC;
            S_ACC:       if (cnt == 8'd0) state_nx = S_REL;
            S_REL:       if (cnt == 8'd0) state_nx = S_DONE;
            S_DONE:                      state_nx = S_IDLE;
            default:                     state_nx = S_IDLE;
        endcase

        if (state_nx != state) begin
            cnt_nx = phase_len(state_nx);
        end else begin
            cnt_nx = (cnt != 8'd0) ? cnt - 8'd1 : cnt;
        end
    end

    // Request latch: plain data, only meaningful while a cycle is running.
    always_ff @(posedge clk_cpu) begin
        if (state == S_IDLE && accept) begin
            kind_l  <= req_kind;
            stack_l <= req_stack;
            addr_l  <= req_addr;
            wdata_l <= req_wdata;
        end
    end

    // Read capture and block tracking
    always_ff @(posedge clk_cpu or posedge sys_reset) begin
        if (sys_reset) begin
            rdata    <= 8'h00;
            blk_seen <= 1'b0;
        end else begin
            if (state == S_IDLE && accept) begin
                blk_seen <= 1'b0;
            end else if (state == S_ACC && !vu_blk_n) begin
                blk_seen <= 1'b1;
            end
            if (state == S_ACC && cnt == 8'd0 && !is_wr) begin
                rdata <= vu_shd_i;
            end
        end
    end

    // Output decode
    always_comb begin
        busy          = 1'b0;
        ack           = 1'b0;
        vu_shap_n     = 8'hFF;
        vu_shavv_n    = 8'hFF;
        vu_shd_o      = 8'h00;
        vu_shd_oe     = 1'b0;
        vu_ras_n      = 1'b1;
        vu_cas_n      = 1'b1;
        vu_zpzu_n     = 1'b1;
        vu_chtzu_n    = 1'b1;
        vu_zpvv_n     = 1'b1;
        vu_chtvv_n    = 1'b1;
        vu_stack      = 1'b0;
        vu_strob_sost = 1'b0;

        case (state)
            S_STAT, S_STAT_HOLD: begin
                busy          = 1'b1;
                vu_stack      = stack_l;
                vu_shd_oe     = 1'b1;
                vu_shd_o      = psw_of(kind_l, stack_l);
                vu_strob_sost = (state == S_STAT);
            end
            S_ROW, S_COL, S_ACC, S_REL: begin
                busy     = 1'b1;
                vu_stack = stack_l;
                if (is_wr) begin
                    vu_shd_oe = 1'b1;
                    vu_shd_o  = wdata_l;
                end
                if (is_mem) begin
                    vu_ras_n  = 1'b0;
                    // Row address only in ROW; column address from COL to the end
                    vu_shap_n = (state == S_ROW) ? ~addr_l[7:0] : ~addr_l[15:8];
                    vu_cas_n  = (state == S_ROW);
                end else begin
                    vu_shavv_n = ~addr_l[7:0];
                end
                if (state == S_ACC) begin
                    vu_chtzu_n = !(is_mem && !is_wr);
                    vu_zpzu_n  = !(is_mem && is_wr);
                    vu_chtvv_n = !(!is_mem && !is_wr);
                    vu_zpvv_n  = !(!is_mem && is_wr);
                end
            end
            S_DONE: begin
                ack = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_vu_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_vu_bus_initiator
//
// Table of bus-cycle vectors applied through one transaction task, with a
// scoreboard queue holding expected rdata/blk_seen/latency per request, plus
// hand-written sequences for ignored requests and reset in mid-cycle.
// ---------------------------------------------------------------------------
module tb_vu_bus_initiator;

    logic        clk_cpu = 1'b0;
    logic        sys_reset;
    logic        req;
    logic [2:0]  req_kind;
    logic        req_stack;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        busy, ack, blk_seen;
    logic [7:0]  rdata;
    logic [7:0]  vu_shap_n, vu_shavv_n, vu_shd_o, vu_shd_i;
    logic        vu_shd_oe;
    logic        vu_ras_n, vu_cas_n, vu_zpzu_n, vu_chtzu_n, vu_zpvv_n, vu_chtvv_n;
    logic        vu_stack, vu_strob_sost, vu_blk_n;
    logic        blk_en;

    always #5 clk_cpu = ~clk_cpu;

    // Responder pulls ~BLK low while any read/write strobe is active.
    assign vu_blk_n = !(blk_en && (!vu_zpzu_n || !vu_chtzu_n || !vu_zpvv_n || !vu_chtvv_n));

    vu_bus_initiator dut (
        .clk_cpu(clk_cpu), .sys_reset(sys_reset),
        .req(req), .req_kind(req_kind), .req_stack(req_stack),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .ack(ack), .rdata(rdata), .blk_seen(blk_seen),
        .vu_shap_n(vu_shap_n), .vu_shavv_n(vu_shavv_n),
        .vu_shd_o(vu_shd_o), .vu_shd_oe(vu_shd_oe), .vu_shd_i(vu_shd_i),
        .vu_ras_n(vu_ras_n), .vu_cas_n(vu_cas_n),
        .vu_zpzu_n(vu_zpzu_n), .vu_chtzu_n(vu_chtzu_n),
        .vu_zpvv_n(vu_zpvv_n), .vu_chtvv_n(vu_chtvv_n),
        .vu_stack(vu_stack), .vu_strob_sost(vu_strob_sost), .vu_blk_n(vu_blk_n)
    );

    typedef struct {
        logic [2:0]  kind;
        logic        stack;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  resp;
        logic        blk;
        logic [7:0]  psw;
        logic [7:0]  row;   // expected shap_n with RAS only, or shavv_n for I/O
        logic [7:0]  col;   // expected shap_n with CAS low (memory only)
        int          sidx;  // 0 chtzu, 1 zpzu, 2 chtvv, 3 zpvv
        int          lat;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        logic       blk;
        int         lat;
    } exp_t;

    vec_t       vecs[6];
    exp_t       sbq[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] model_rdata;

    // Free-running monitors
    int ack_cnt = 0;
    int zpvv_cnt = 0;
    int act_cnt = 0;
    always @(negedge clk_cpu) begin
        if (ack) ack_cnt++;
        if (!vu_zpvv_n) zpvv_cnt++;
        if (busy || vu_strob_sost || !vu_ras_n || !vu_cas_n || !vu_zpzu_n ||
            !vu_chtzu_n || !vu_zpvv_n || !vu_chtvv_n || vu_shd_oe) act_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] idle_word();
        return {vu_shap_n, vu_shavv_n, vu_shd_o, vu_shd_oe, vu_ras_n, vu_cas_n,
                vu_zpzu_n, vu_chtzu_n, vu_zpvv_n, vu_chtvv_n, vu_strob_sost};
    endfunction
    localparam logic [31:0] IDLE_EXP = {8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1,
                                        1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    task automatic run_txn(input vec_t v);
        exp_t       e, got_e;
        bit         rd, mem, wr, got;
        int         cyc, strob_n, psw_bad, excl_bad, io_bad, dat_bad, n, tot;
        int         lows[4];
        logic [7:0] row_v, col_v;
        logic [31:0] idle_at_ack;
        logic       busy_at_ack;
        rd  = (v.kind == 3'd0) || (v.kind == 3'd2) || (v.kind == 3'd4);
        wr  = !rd;
        mem = (v.kind == 3'd0) || (v.kind == 3'd1) || (v.kind == 3'd4);
        e.rdata = rd ? v.resp : model_rdata;
        e.blk   = v.blk;
        e.lat   = v.lat;
        sbq.push_back(e);
        if (rd) model_rdata = v.resp;

        strob_n = 0; psw_bad = 0; excl_bad = 0; io_bad = 0; dat_bad = 0;
        lows = '{0, 0, 0, 0};
        row_v = 8'hFF; col_v = 8'hFF; got = 0; idle_at_ack = '0; busy_at_ack = 1'b1;

        @(negedge clk_cpu);
        req = 1'b1; req_kind = v.kind; req_stack = v.stack;
        req_addr = v.addr; req_wdata = v.wdata;
        vu_shd_i = v.resp; blk_en = v.blk;
        @(negedge clk_cpu);
        req = 1'b0; req_kind = 3'd7; req_addr = 16'h0; req_wdata = 8'h0;
        cyc = 1;
        while (cyc <= 60) begin
            if (ack) begin
                got = 1;
                idle_at_ack = idle_word();
                busy_at_ack = busy;
                break;
            end
            if (vu_strob_sost) begin
                strob_n++;
                if (!vu_shd_oe || vu_shd_o !== v.psw || vu_stack !== v.stack) psw_bad++;
            end
            if (cyc == 5 && (vu_strob_sost || !vu_shd_oe || vu_shd_o !== v.psw)) psw_bad++;
            n = 0;
            if (!vu_chtzu_n) begin lows[0]++; n++; end
            if (!vu_zpzu_n)  begin lows[1]++; n++; end
            if (!vu_chtvv_n) begin lows[2]++; n++; end
            if (!vu_zpvv_n)  begin lows[3]++; n++; end
            if (n > 1) excl_bad++;
            if (mem) begin
                if (!vu_ras_n && vu_cas_n) row_v = vu_shap_n;
                if (!vu_cas_n) col_v = vu_shap_n;
            end else begin
                if (!vu_ras_n || !vu_cas_n) io_bad++;
                if (vu_shavv_n != 8'hFF) row_v = vu_shavv_n;
            end
            if (cyc >= 6 && cyc < v.lat) begin
                if (wr) begin
                    if (!vu_shd_oe || vu_shd_o !== v.wdata) dat_bad++;
                end else if (vu_shd_oe) dat_bad++;
            end
            @(negedge clk_cpu);
            cyc++;
        end

        check("ack_seen", 32'(got), 32'd1);
        got_e = sbq.pop_front();
        check("latency", cyc, got_e.lat);
        check("rdata", 32'(rdata), 32'(got_e.rdata));
        check("blk_seen", 32'(blk_seen), 32'(got_e.blk));
        check("idle_at_ack", idle_at_ack, IDLE_EXP);
        check("busy_at_ack", 32'(busy_at_ack), 32'd0);
        check("strob_cycles", strob_n, 4);
        check("psw_errs", psw_bad, 0);
        check("row_addr", 32'(row_v), 32'(v.row));
        if (mem) check("col_addr", 32'(col_v), 32'(v.col));
        check("strobe_len", lows[v.sidx], 8);
        tot = lows[0] + lows[1] + lows[2] + lows[3];
        check("strobe_total", tot, 8);
        check("strobe_excl", excl_bad, 0);
        check("io_rascas", io_bad, 0);
        check("data_drive", dat_bad, 0);
        @(negedge clk_cpu);
        check("post_idle", {31'd0, busy | ack}, 32'd0);
    endtask

    int a0, z0, t;

    initial begin
        sys_reset = 1'b1; req = 1'b0; req_kind = 3'd0; req_stack = 1'b0;
        req_addr = 16'h0; req_wdata = 8'h0; vu_shd_i = 8'h00; blk_en = 1'b0;
        model_rdata = 8'h00;

        //            kind stk addr      wd     resp   blk psw    row    col    s  lat
        vecs[0] = '{3'd0, 1'b0, 16'h1234, 8'h00, 8'h5A, 1'b1, 8'h82, 8'hCB, 8'hED, 0, 22};
        vecs[1] = '{3'd1, 1'b1, 16'hFFFF, 8'hA5, 8'hEE, 1'b0, 8'h04, 8'h00, 8'h00, 1, 22};
        vecs[2] = '{3'd3, 1'b0, 16'h0010, 8'h23, 8'h99, 1'b0, 8'h10, 8'hEF, 8'hFF, 3, 19};
        vecs[3] = '{3'd2, 1'b0, 16'h001B, 8'h00, 8'h80, 1'b0, 8'h42, 8'hE4, 8'hFF, 2, 19};
        vecs[4] = '{3'd4, 1'b0, 16'hBEEF, 8'h00, 8'h3C, 1'b1, 8'hA2, 8'h10, 8'h41, 0, 22};
        vecs[5] = '{3'd2, 1'b1, 16'hAB55, 8'h00, 8'hC3, 1'b1, 8'h46, 8'hAA, 8'hFF, 2, 19};

        #12;
        check("reset_bus", idle_word(), IDLE_EXP);
        check("reset_ctl", {22'd0, busy, ack, rdata, blk_seen, vu_stack}, 32'd0);
        @(negedge clk_cpu);
        sys_reset = 1'b0;
        @(negedge clk_cpu);

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Requests while busy and during DONE are dropped
        a0 = ack_cnt; z0 = zpvv_cnt;
        @(negedge clk_cpu);
        req = 1'b1; req_kind = 3'd0; req_addr = 16'h0102; vu_shd_i = 8'h11; blk_en = 1'b0;
        @(negedge clk_cpu);
        req = 1'b0;
        repeat (5) @(negedge clk_cpu);
        req = 1'b1; req_kind = 3'd3; req_addr = 16'h0044; req_wdata = 8'h66;
        @(negedge clk_cpu);
        req = 1'b0;
        t = 0;
        while (!ack && t < 40) begin @(negedge clk_cpu); t++; end
        check("busy_ack_seen", {31'd0, ack}, 32'd1);
        req = 1'b1; req_kind = 3'd1;
        @(negedge clk_cpu);
        req = 1'b0;
        repeat (30) @(negedge clk_cpu);
        check("busy_one_ack", ack_cnt - a0, 1);
        check("busy_no_iowr", zpvv_cnt - z0, 0);
        check("busy_rdata", 32'(rdata), 32'h11);
        model_rdata = 8'h11;

        // Illegal kind is ignored
        a0 = ack_cnt; t = act_cnt;
        @(negedge clk_cpu);
        req = 1'b1; req_kind = 3'd6; req_addr = 16'h5555;
        @(negedge clk_cpu);
        req = 1'b0;
        repeat (25) @(negedge clk_cpu);
        check("illegal_ack", ack_cnt - a0, 0);
        check("illegal_activity", act_cnt - t, 0);

        // Reset in the middle of a write strobe
        @(negedge clk_cpu);
        req = 1'b1; req_kind = 3'd1; req_addr = 16'h4321; req_wdata = 8'h77;
        @(negedge clk_cpu);
        req = 1'b0;
        t = 0;
        while (vu_zpzu_n && t < 40) begin @(negedge clk_cpu); t++; end
        check("rst_reached_acc", {31'd0, vu_zpzu_n}, 32'd0);
        repeat (3) @(negedge clk_cpu);
        #2 sys_reset = 1'b1;
        #1;
        check("rst_async_bus", {28'd0, vu_zpzu_n, vu_ras_n, vu_cas_n, vu_shd_oe}, 32'hE);
        check("rst_async_ctl", {23'd0, busy, rdata}, 32'd0);
        check("rst_async_idle", idle_word(), IDLE_EXP);
        @(negedge clk_cpu);
        sys_reset = 1'b0;
        model_rdata = 8'h00;
        @(negedge clk_cpu);
        run_txn(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
